// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension issue controller.
// Holds the controller state encoding, funct3 codes, fast-path constants and the held-op payload.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3_W = 3;
    localparam int unsigned RD_W = 5;

    localparam logic [F3_W-1:0] R_INST_FUNC3_MUL    = 3'd0;
    localparam logic [F3_W-1:0] R_INST_FUNC3_MULH   = 3'd1;
    localparam logic [F3_W-1:0] R_INST_FUNC3_MULHSU = 3'd2;
    localparam logic [F3_W-1:0] R_INST_FUNC3_MULHU  = 3'd3;
    localparam logic [F3_W-1:0] R_INST_FUNC3_DIV    = 3'd4;
    localparam logic [F3_W-1:0] R_INST_FUNC3_DIVU   = 3'd5;
    localparam logic [F3_W-1:0] R_INST_FUNC3_REM    = 3'd6;
    localparam logic [F3_W-1:0] R_INST_FUNC3_REMU   = 3'd7;

    localparam logic [XLEN-1:0] FP_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] FP_INT_MIN  = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_BUSY = 3'd1,
        DIV_BUSY = 3'd2,
        RESP     = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    // Operation held from accept until the unit reports done.
    typedef struct packed {
        logic [F3_W-1:0] func3;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [RD_W-1:0] rd;
    } mop_t;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div_op(input logic [F3_W-1:0] func3);
        return func3[2];
    endfunction

endpackage

// File: rtl/muldiv_fastpath.sv
// Single-cycle resolution of divide-by-zero and signed overflow for the divide group.
// Purely combinational; outputs are only meaningful while the request is presented.
module muldiv_fastpath
    import muldiv_pkg::*;
(
    input  logic [F3_W-1:0] func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            hit_c,
    output logic [XLEN-1:0] result_c
);

    logic div_op;
    logic is_rem;
    logic is_signed;
    logic div_by_zero;
    logic overflow;

    always_comb begin
        div_op      = is_div_op(func3);
        is_rem      = func3[1];
        is_signed   = ~func3[0];
        div_by_zero = div_op && (rs2 == '0);
        overflow    = div_op && is_signed && (rs1 == FP_INT_MIN) && (rs2 == FP_ALL_ONES);
        hit_c       = div_by_zero || overflow;
        result_c    = '0;
        // Divide by zero wins: REM returns the dividend, DIV returns all ones.
        if (div_by_zero) begin
            result_c = is_rem ? rs1 : FP_ALL_ONES;
        end else if (overflow) begin
            result_c = is_rem ? '0 : FP_INT_MIN;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Issue/sequencing controller between execute and the iterative multiplier/divider.
// One op in flight; result held until writeback accepts it; flush drains units that cannot abort.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter bit DIV_EN       = 1'b1,
    parameter bit FAST_PATH_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [F3_W-1:0] req_func3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [RD_W-1:0] req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [RD_W-1:0] resp_rd,
    output logic            busy,
    output logic            mul_valid,
    output logic            div_valid,
    output logic            mul_stall,
    output logic            div_stall,
    output logic [F3_W-1:0] mul_op,
    output logic [F3_W-1:0] div_op,
    output logic [XLEN-1:0] mul_op1,
    output logic [XLEN-1:0] mul_op2,
    output logic [XLEN-1:0] div_op1,
    output logic [XLEN-1:0] div_op2,
    input  logic            mul_ready,
    input  logic            div_ready,
    input  logic [XLEN-1:0] mul_out,
    input  logic [XLEN-1:0] div_out
);

    state_t          state_q;
    state_t          state_d;
    mop_t            req_q;
    logic            req_load;
    logic            launch_mul;
    logic            launch_div;
    logic [XLEN-1:0] resp_data_d;
    logic [RD_W-1:0] resp_rd_d;
    logic            fp_hit_c;
    logic [XLEN-1:0] fp_result_c;
    logic            drain_done;

    // Fast path only exists when enabled; otherwise every divide goes to the unit.
    if (FAST_PATH_EN) begin : g_fastpath
        muldiv_fastpath u_fastpath (
            .func3   (req_func3),
            .rs1     (req_rs1),
            .rs2     (req_rs2),
            .hit_c   (fp_hit_c),
            .result_c(fp_result_c)
        );
    end else begin : g_no_fastpath
        assign fp_hit_c    = 1'b0;
        assign fp_result_c = '0;
    end

    assign drain_done = is_div_op(req_q.func3) ? div_ready : mul_ready;

    // Next-state and datapath control; flush outranks every other event.
    always_comb begin
        state_d     = state_q;
        req_load    = 1'b0;
        launch_mul  = 1'b0;
        launch_div  = 1'b0;
        resp_data_d = resp_data;
        resp_rd_d   = resp_rd;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    req_load = 1'b1;
                    if (!is_div_op(req_func3)) begin
                        state_d    = MUL_BUSY;
                        launch_mul = 1'b1;
                    end else if (fp_hit_c || !DIV_EN) begin
                        state_d     = RESP;
                        resp_data_d = fp_hit_c ? fp_result_c : '0;
                        resp_rd_d   = req_rd;
                    end else begin
                        state_d    = DIV_BUSY;
                        launch_div = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (flush) begin
                    state_d = mul_ready ? IDLE : DRAIN;
                end else if (mul_ready) begin
                    state_d     = RESP;
                    resp_data_d = mul_out;
                    resp_rd_d   = req_q.rd;
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    state_d = div_ready ? IDLE : DRAIN;
                end else if (div_ready) begin
                    state_d     = RESP;
                    resp_data_d = div_out;
                    resp_rd_d   = req_q.rd;
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered handshake/launch outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            mul_valid  <= 1'b0;
            div_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            resp_valid <= (state_d == RESP);
            mul_valid  <= launch_mul;
            div_valid  <= launch_div;
        end
    end

    // Held op and result registers; op stays put until the next accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q     <= '0;
            resp_data <= '0;
            resp_rd   <= '0;
        end else begin
            if (req_load) begin
                req_q.func3 <= req_func3;
                req_q.rs1   <= req_rs1;
                req_q.rs2   <= req_rs2;
                req_q.rd    <= req_rd;
            end
            resp_data <= resp_data_d;
            resp_rd   <= resp_rd_d;
        end
    end

    assign mul_op    = req_q.func3;
    assign mul_op1   = req_q.rs1;
    assign mul_op2   = req_q.rs2;
    assign div_op    = req_q.func3;
    assign div_op1   = req_q.rs1;
    assign div_op2   = req_q.rs2;
    assign mul_stall = 1'b0;
    assign div_stall = 1'b0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider units of programmable latency.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_func3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        busy;
    logic        mul_valid;
    logic        div_valid;
    logic        mul_stall;
    logic        div_stall;
    logic [2:0]  mul_op;
    logic [2:0]  div_op;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        mul_ready;
    logic        div_ready;
    logic [31:0] mul_out;
    logic [31:0] div_out;

    int n_checks = 0;
    int n_fail   = 0;
    int mul_lat  = 4;
    int div_lat  = 8;
    int mul_pulses = 0;
    int div_pulses = 0;
    int mcnt = 0;
    int dcnt = 0;

    muldiv_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_func3 (req_func3),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_rd    (req_rd),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_rd   (resp_rd),
        .busy      (busy),
        .mul_valid (mul_valid),
        .div_valid (div_valid),
        .mul_stall (mul_stall),
        .div_stall (div_stall),
        .mul_op    (mul_op),
        .div_op    (div_op),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .div_op1   (div_op1),
        .div_op2   (div_op2),
        .mul_ready (mul_ready),
        .div_ready (div_ready),
        .mul_out   (mul_out),
        .div_out   (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mul_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        if (op == 3'd0) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end
        p = ea * eb;
        return (op == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            3'd4:    return 32'($signed(a) / $signed(b));
            3'd5:    return a / b;
            3'd6:    return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // Unit models sample the launch pulse and operands just after each rising edge.
    initial begin
        mul_ready = 1'b0;
        mul_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_ready = 1'b0;
            if (!rstn) begin
                mcnt = 0;
            end else if (mul_valid) begin
                mul_pulses++;
                mcnt = mul_lat;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mul_ready = 1'b1;
                    mul_out   = mul_model(mul_op, mul_op1, mul_op2);
                end
            end
        end
    end

    initial begin
        div_ready = 1'b0;
        div_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            div_ready = 1'b0;
            if (!rstn) begin
                dcnt = 0;
            end else if (div_valid) begin
                div_pulses++;
                dcnt = div_lat;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    div_ready = 1'b1;
                    div_out   = div_model(div_op, div_op1, div_op2);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        check("req_ready_pre", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_func3 = f3;
        req_rs1   = a;
        req_rs2   = b;
        req_rd    = rd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("resp_timeout", {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_cyc);
        int cyc;
        issue(f3, a, b, rd);
        wait_resp(cyc);
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_rd"}, 32'(resp_rd), 32'(rd));
        if (exp_cyc >= 0) check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_done"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        int p;
        logic bad;
        rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_func3 = '0;
        req_rs1 = '0; req_rs2 = '0; req_rd = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_launch", {30'b0, mul_valid, div_valid}, 32'd0);
        check("rst_stall", {30'b0, mul_stall, div_stall}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        check("rst_ops", mul_op1 | mul_op2 | 32'(div_op), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Multiply through the unit.
        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, -1);
        check("mul_pulses_1", 32'(mul_pulses), 32'd1);
        check("div_pulses_0", 32'(div_pulses), 32'd0);

        // Fast-path divides: response on the cycle after accept, no divider launch.
        run_op("div_by0", 3'd4, 32'd100, 32'd0, 5'd5, 32'hFFFF_FFFF, 0);
        run_op("remu_by0", 3'd7, 32'd100, 32'd0, 5'd6, 32'd100, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 0);
        check("fast_no_launch", 32'(div_pulses), 32'd0);

        // Unsigned op with overflow operands and signed divides use the divider.
        run_op("divu_nofp", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, -1);
        run_op("div_unit", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFA, -1);
        run_op("rem_unit", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd11, 32'hFFFF_FFFE, -1);
        check("div_pulses_3", 32'(div_pulses), 32'd3);

        // Flush 10 cycles after accept: drain until the unit reports done.
        mul_lat = 16;
        issue(3'd0, 32'd5, 32'd6, 5'd12);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_state_drain", 32'(dut.state_q), 32'(DRAIN));
        check("flush_busy", {31'b0, busy}, 32'd1);
        bad = 1'b0;
        n = 0;
        while (!mul_ready && n < 100) begin
            if (req_ready || resp_valid) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check("drain_ready_seen", {31'b0, mul_ready}, 32'd1);
        check("drain_hold", {31'b0, bad}, 32'd0);
        check("drain_rr_at_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("drain_rr_after", {31'b0, req_ready}, 32'd1);
        check("drain_no_resp", {31'b0, resp_valid}, 32'd0);

        // Flush on the launch cycle still drains.
        mul_lat = 6;
        issue(3'd1, 32'd3, 32'd4, 5'd13);
        check("launch_pulse", {31'b0, mul_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("launch_flush_drain", 32'(dut.state_q), 32'(DRAIN));
        check("launch_pulse_once", {31'b0, mul_valid}, 32'd0);
        wait_idle();
        check("launch_flush_no_resp", {31'b0, resp_valid}, 32'd0);

        // Flush coinciding with unit done goes straight to idle.
        mul_lat = 5;
        issue(3'd0, 32'd2, 32'd2, 5'd14);
        n = 0;
        while (!mul_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready_idle", {30'b0, busy, req_ready}, 32'd1);
        check("flush_ready_no_resp", {31'b0, resp_valid}, 32'd0);

        // Flush in RESP together with resp_ready drops the response.
        mul_lat = 4;
        issue(3'd0, 32'd2, 32'd3, 5'd15);
        wait_resp(cyc);
        flush = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b0;
        check("resp_flush_valid", {31'b0, resp_valid}, 32'd0);
        check("resp_flush_rr", {31'b0, req_ready}, 32'd1);

        // Flush in IDLE blocks the accept.
        req_valid = 1'b1; req_func3 = 3'd0; req_rs1 = 32'd1; req_rs2 = 32'd1;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", {30'b0, busy, mul_valid}, 32'd0);
        check("mul_pulses_5", 32'(mul_pulses), 32'd5);

        // Back-pressure: response held stable, then next op accepted one cycle after handshake.
        issue(3'd0, 32'd9, 32'd9, 5'd16);
        wait_resp(cyc);
        check("bp_data", resp_data, 32'h0000_0051);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!resp_valid || resp_data != 32'h51 || resp_rd != 5'd16) bad = 1'b1;
        end
        check("bp_stable", {31'b0, bad}, 32'd0);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_func3 = 3'd3; req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'hFFFF_FFFF; req_rd = 5'd17;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_one_handshake", {31'b0, resp_valid}, 32'd0);
        check("bp_no_b2b", {30'b0, busy, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_accept", {30'b0, busy, mul_valid}, 32'd3);
        wait_resp(cyc);
        check("mulhu_data", resp_data, 32'hFFFF_FFFE);
        check("mulhu_rd", 32'(resp_rd), 32'd17);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("mul_pulses_7", 32'(mul_pulses), 32'd7);

        // Asynchronous reset during DIV_BUSY.
        p = div_pulses;
        issue(3'd5, 32'd1000, 32'd7, 5'd18);
        repeat (3) @(negedge clk);
        check("div_busy_state", 32'(dut.state_q), 32'(DIV_BUSY));
        rstn = 1'b0;
        #1;
        check("arst_state", 32'(dut.state_q), 32'(IDLE));
        check("arst_flags", {29'b0, resp_valid, busy, req_ready}, 32'd1);
        check("arst_ops", div_op1 | div_op2, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_op("divu_after_rst", 3'd5, 32'd35, 32'd6, 5'd19, 32'd5, -1);
        check("div_pulses_after_rst", 32'(div_pulses), 32'(p + 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Issue/sequencing controller between the execute stage and the iterative M-extension units (shift-add multiplier, iterative divider). Accepts one M-op at a time over valid/ready and dispatches it to the correct unit. Handles divide-by-zero and signed-overflow in a single cycle without using the divider. Registers the result until writeback accepts it, and discards in-flight work on a pipeline flush.

Parameters:
DIV_EN, 1, 0 = divider absent; DIV/DIVU/REM/REMU use only the fast-path results, with the quotient forced to 0 when no fast path applies.
FAST_PATH_EN, 1, 1 = resolve divide-by-zero and overflow in the controller; 0 = send every divide op to the divider.

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
flush  in  1  kill current op (branch mispredict/trap)
req_valid  in  1  M-op request
req_ready  out  1  controller can accept
req_func3  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
req_rd  in  5  destination tag
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts
resp_data  out  32  result
resp_rd  out  5  destination tag of result
busy  out  1  state != IDLE
mul_valid, div_valid  out  1  one-cycle launch pulse to the unit
mul_stall, div_stall  out  1  unit stall; tied 0 by this block
mul_op, div_op  out  3  funct3 to the unit, from the held register
mul_op1/op2, div_op1/op2  out  32  operands to the unit, from the held registers
mul_ready, div_ready  in  1  unit done pulse, result valid this cycle
mul_out, div_out  in  32  unit result

Behaviour:
- Reset values:
  - state = IDLE; resp_valid = 0; busy = 0; mul_valid = div_valid = 0.
  - req_ready = 1 after reset.
  - resp_data, resp_rd and the operand/op registers reset to 0.
- State machine: IDLE, MUL_BUSY, DIV_BUSY, RESP, DRAIN.
- req_ready = (state == IDLE). Accept = req_valid && req_ready && ~flush.
- On accept:
  - Latch func3, rs1, rs2 and rd.
  - func3[2] = 0: go to MUL_BUSY.
  - func3[2] = 1 with a fast-path case (FAST_PATH_EN = 1): write the result register and go to RESP. resp_valid rises the cycle after accept.
  - Otherwise: go to DIV_BUSY.
- Fast-path results:
  - rs2 == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed ops with rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Launch and unit hold:
  - mul_valid/div_valid is high for exactly the first cycle in *_BUSY and never again for that op.
  - Op and operand outputs stay stable from launch until the unit's ready cycle inclusive, because the unit selects its output slice from op.
- Unit completion:
  - In MUL_BUSY/DIV_BUSY, *_ready = 1 captures *_out into resp_data and goes to RESP.
  - Ready from the unit not currently selected is ignored.
- RESP:
  - resp_valid = 1; resp_data and resp_rd are held stable while resp_ready = 0.
  - resp_valid && resp_ready goes to IDLE.
  - No back-to-back accept in the same cycle; the next request is accepted one cycle later.
- Flush, which takes priority over every other event in the same cycle:
  - IDLE: the request is not accepted.
  - *_BUSY: go to DRAIN. The unit cannot abort, so DRAIN waits for the matching *_ready, discards the result, then goes to IDLE. req_ready = 0 throughout DRAIN.
  - Flush on the launch cycle itself still goes to DRAIN.
  - Flush arriving in the same cycle as *_ready goes straight to IDLE with no resp.
  - RESP: drop resp_valid and go to IDLE. The response must not appear if the flush and resp_ready coincide.
  - DRAIN: no effect.
- busy is high in every state except IDLE.
- Latency: the unit's latency plus 2 cycles (launch register, result register). Fast paths: resp_valid on accept+1.
- Asynchronous reset mid-operation returns everything to reset values immediately. The unit is reset by the same rstn.

Decomposition:
- A shared package muldiv_pkg holds:
  - the state_t enum;
  - the funct3 constants (reuse the R_INST_FUNC3_* names for the MUL group, add DIV/DIVU/REM/REMU);
  - the fast-path constants 0xFFFFFFFF and 0x80000000.
- One sub-module, muldiv_fastpath: combinational detection of the fast-path case plus its result. It is kept separate so it can be unit-tested and removed when FAST_PATH_EN = 0.

Test Plan:
1. MUL, rs1 = 7, rs2 = 0xFFFFFFFD -> one mul_valid pulse, resp_data 0xFFFFFFEB with resp_rd matching; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
2. DIV, rs1 = 100, rs2 = 0 -> no div_valid, resp_valid at accept+1, data 0xFFFFFFFF; REMU 100, 0 -> 100.
3. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both via fast path.
4. MUL accepted, flush 10 cycles later -> DRAIN, req_ready = 0 until mul_ready, no resp_valid, req_ready = 1 the cycle after.
5. MUL result with resp_ready held 0 for 5 cycles -> resp_valid/data/rd stable; release -> one handshake; next req accepted the following cycle.
6. Assert rstn = 0 during DIV_BUSY -> state IDLE, resp_valid 0, req_ready 1 after release; a new DIVU 35/6 -> 5.
